hdmi_fifo_pixel_read: RTL and testbench

- HDMI-clock-side consumer of the 4 x 64-byte line FIFO RAM that the PSRAM read stage fills in the psramclk domain.
- Reads 32-bit words (2 x RGB565 pixels per word), expands each pixel to RGB888 and presents one pixel per active video cycle to the HDMI encoder.
- Returns a read-pointer update pulse per consumed 64-byte block, which the PSRAM stage synchronises into its own domain.

---
 rtl/hdmi_pkg.sv | 28 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/hdmi_fifo_pixel_read.sv | 162 ++++++++++++++++
 tb/tb_hdmi_fifo_pixel_read.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI-side line FIFO reader: FSM encoding, FIFO geometry, pixel expansion.
// Pure declarations; no latency and no backpressure.
package hdmi_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_FILL = 2'd1;
  localparam logic [1:0] ST_ARMED     = 2'd2;
  localparam logic [1:0] ST_ACTIVE    = 2'd3;

  localparam int FIFO_BLKS     = 4;
  localparam int WORDS_PER_BLK = 16;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Replicating the top bits keeps full-scale white at 0xFF per channel.
  function automatic rgb888_t rgb565_to_888(input logic [15:0] p);
    rgb888_t c;
    c.r = {p[15:11], p[15:13]};
    c.g = {p[10:5],  p[10:9]};
    c.b = {p[4:0],   p[4:2]};
    return c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchroniser into the local clock domain.
// Latency 2 clk cycles; no backpressure.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hdmi_fifo_pixel_read.sv
// Reads RGB565 word pairs from the line FIFO RAM, emits one RGB888 pixel per vid_de; vid_de->pix_de latency 2.
// No stall: late data only sets the sticky underrun flag. Optional HDMI_UNDERRUN_CNT_EN adds underrun_cnt.
module hdmi_fifo_pixel_read
  import hdmi_pkg::*;
#(
  parameter int HDMI_HSIZE  = 1280,
  parameter int HDMI_VSIZE  = 720,
  parameter int RPT_PULSE_W = 4
) (
  input  logic        hdclk,
  input  logic        rst_hdclk,
  input  logic        run_hdmi,
  input  logic        fifo_empty,
  input  logic        vid_de,
  input  logic        vid_fs,
  output logic [5:0]  fifo_radr,
  input  logic [31:0] fifo_rdata,
  output logic        fifo_rpt_update_hdclk,
  output logic        pix_de,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic        underrun
`ifdef HDMI_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_cnt
`endif
);

  localparam int BLK_W  = $clog2(FIFO_BLKS);
  localparam int WORD_W = $clog2(WORDS_PER_BLK);
  localparam int CNT_W  = $clog2(RPT_PULSE_W + 1);

  // Whole blocks per line keep the block pointer aligned with the PSRAM writer.
  if ((HDMI_HSIZE % 32) != 0 || HDMI_VSIZE < 1 || RPT_PULSE_W < 2) begin : g_bad_cfg
    $error("hdmi_fifo_pixel_read: unsupported size parameters");
  end

  logic              run_s;
  logic              fifo_empty_s;
  logic [1:0]        state;
  logic [BLK_W-1:0]  blk;
  logic [WORD_W-1:0] word;
  logic              half;
  logic [CNT_W-1:0]  rpt_cnt;
  logic              de_d1;
  logic              act_d1;
  logic              half_d1;
  rgb888_t           pix_q;
  logic              consume;
  logic              blk_end;
  logic              ur_hit;

  sync_2ff u_sync_run (
    .clk (hdclk),
    .rst (rst_hdclk),
    .d   (run_hdmi),
    .q   (run_s)
  );

  sync_2ff u_sync_empty (
    .clk (hdclk),
    .rst (rst_hdclk),
    .d   (fifo_empty),
    .q   (fifo_empty_s)
  );

  assign consume = (state == ST_ACTIVE) && vid_de;
  assign blk_end = consume && half && (word == WORD_W'(WORDS_PER_BLK - 1));
  // Mid-block sample: the PSRAM read pointer has settled by word 8.
  assign ur_hit  = consume && !half && (word == WORD_W'(8)) && fifo_empty_s;

  assign fifo_radr             = {blk, word};
  assign fifo_rpt_update_hdclk = (rpt_cnt != '0);
  assign pix_r                 = pix_q.r;
  assign pix_g                 = pix_q.g;
  assign pix_b                 = pix_q.b;

  always_ff @(posedge hdclk or posedge rst_hdclk) begin
    if (rst_hdclk) begin
      state   <= ST_IDLE;
      blk     <= '0;
      word    <= '0;
      half    <= 1'b0;
      rpt_cnt <= '0;
    end else if (!run_s) begin
      state   <= ST_IDLE;
      blk     <= '0;
      word    <= '0;
      half    <= 1'b0;
      rpt_cnt <= '0;
    end else begin
      if (blk_end)
        rpt_cnt <= CNT_W'(RPT_PULSE_W);
      else if (rpt_cnt != '0)
        rpt_cnt <= rpt_cnt - CNT_W'(1);

      case (state)
        ST_IDLE: begin
          blk   <= '0;
          word  <= '0;
          half  <= 1'b0;
          state <= ST_WAIT_FILL;
        end
        ST_WAIT_FILL: if (!fifo_empty_s) state <= ST_ARMED;
        ST_ARMED:     if (vid_fs) state <= ST_ACTIVE;
        ST_ACTIVE: begin
          if (vid_de) begin
            half <= ~half;
            if (half)    word <= word + WORD_W'(1);
            if (blk_end) blk  <= blk + BLK_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge hdclk or posedge rst_hdclk) begin
    if (rst_hdclk)
      underrun <= 1'b0;
    else if (state == ST_IDLE && run_s)
      underrun <= 1'b0;
    else if (ur_hit)
      underrun <= 1'b1;
  end

`ifdef HDMI_UNDERRUN_CNT_EN
  always_ff @(posedge hdclk or posedge rst_hdclk) begin
    if (rst_hdclk)
      underrun_cnt <= '0;
    else if (state == ST_IDLE && run_s)
      underrun_cnt <= '0;
    else if (ur_hit && underrun_cnt != 16'hFFFF)
      underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif

  // Stage 1 waits out the RAM read latency; stage 2 selects and expands the pixel.
  always_ff @(posedge hdclk or posedge rst_hdclk) begin
    if (rst_hdclk) begin
      de_d1   <= 1'b0;
      act_d1  <= 1'b0;
      half_d1 <= 1'b0;
      pix_de  <= 1'b0;
      pix_q   <= '0;
    end else if (!run_s) begin
      de_d1   <= 1'b0;
      act_d1  <= 1'b0;
      half_d1 <= 1'b0;
      pix_de  <= 1'b0;
      pix_q   <= '0;
    end else begin
      de_d1   <= vid_de;
      act_d1  <= consume;
      half_d1 <= half;
      pix_de  <= de_d1;
      pix_q   <= act_d1 ? rgb565_to_888(half_d1 ? fifo_rdata[31:16] : fifo_rdata[15:0]) : '0;
    end
  end

endmodule

// File: tb/tb_hdmi_fifo_pixel_read.sv
// Directed bench for hdmi_fifo_pixel_read with a 1-cycle-latency RAM model behind fifo_radr.
// Covers reset, block sequencing, pulse timing, pixel expansion, underrun and run drop.
module tb_hdmi_fifo_pixel_read;
  import hdmi_pkg::*;

  logic        hdclk = 1'b0;
  logic        rst_hdclk;
  logic        run_hdmi;
  logic        fifo_empty;
  logic        vid_de;
  logic        vid_fs;
  logic [5:0]  fifo_radr;
  logic [31:0] fifo_rdata;
  logic        fifo_rpt_update_hdclk;
  logic        pix_de;
  logic [7:0]  pix_r;
  logic [7:0]  pix_g;
  logic [7:0]  pix_b;
  logic        underrun;
`ifdef HDMI_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  logic [31:0] mem [0:63];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [23:0] cap0;
  logic [23:0] cap1;
  int          pulses;

  always #5 hdclk = ~hdclk;
  always @(posedge hdclk) fifo_rdata <= mem[fifo_radr];

  hdmi_fifo_pixel_read dut (
    .hdclk                 (hdclk),
    .rst_hdclk             (rst_hdclk),
    .run_hdmi              (run_hdmi),
    .fifo_empty            (fifo_empty),
    .vid_de                (vid_de),
    .vid_fs                (vid_fs),
    .fifo_radr             (fifo_radr),
    .fifo_rdata            (fifo_rdata),
    .fifo_rpt_update_hdclk (fifo_rpt_update_hdclk),
    .pix_de                (pix_de),
    .pix_r                 (pix_r),
    .pix_g                 (pix_g),
    .pix_b                 (pix_b),
    .underrun              (underrun)
`ifdef HDMI_UNDERRUN_CNT_EN
    ,
    .underrun_cnt          (underrun_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hdclk);
    #1;
  endtask

  function automatic logic [23:0] exp_pix(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  // Step j: check outputs, then drive inputs for the coming edge. Pointers start at 0.
  task automatic run_line(input int n_de, input int n_steps, input int emp_on,
                          input int emp_off, input int ur_step, output int n_pulses);
    logic        prev_rpt;
    logic        rpt_exp;
    logic [31:0] w;
    logic [15:0] p;
    logic [23:0] pe;
    int          k;
    int          jj;
    n_pulses = 0;
    prev_rpt = fifo_rpt_update_hdclk;
    for (int j = 0; j < n_steps; j++) begin
      jj = (j < n_de) ? j : n_de;
      check("radr", 32'(fifo_radr), 32'((jj / 2) % 64));
      if (j >= 2 && (j - 2) < n_de) begin
        k  = j - 2;
        w  = mem[(k / 2) % 64];
        p  = (k % 2 == 1) ? w[31:16] : w[15:0];
        pe = exp_pix(p);
        check("pix_de", 32'(pix_de), 32'd1);
      end else begin
        pe = 24'h0;
        check("pix_de", 32'(pix_de), 32'd0);
      end
      check("pix_rgb", {8'h0, pix_r, pix_g, pix_b}, {8'h0, pe});
      if (j == 2) cap0 = {pix_r, pix_g, pix_b};
      if (j == 3) cap1 = {pix_r, pix_g, pix_b};
      rpt_exp = (j >= 32) && (((j - 32) % 32) < 4) && ((31 + 32 * ((j - 32) / 32)) < n_de);
      check("rpt", 32'(fifo_rpt_update_hdclk), 32'(rpt_exp));
      if (fifo_rpt_update_hdclk && !prev_rpt) n_pulses++;
      prev_rpt = fifo_rpt_update_hdclk;
      if (ur_step >= 0 && j == ur_step)     check("underrun_pre", 32'(underrun), 32'd0);
      if (ur_step >= 0 && j == ur_step + 1) check("underrun_set", 32'(underrun), 32'd1);
      if (j == emp_on)  fifo_empty = 1'b1;
      if (j == emp_off) fifo_empty = 1'b0;
      vid_de = (j < n_de);
      tick();
    end
  endtask

  initial begin
    rst_hdclk  = 1'b1;
    run_hdmi   = 1'b0;
    fifo_empty = 1'b0;
    vid_de     = 1'b0;
    vid_fs     = 1'b0;
    for (int a = 0; a < 64; a++) mem[a] = {16'(2 * a + 1), 16'(2 * a)};
    tick();
    check("rst_radr",  32'(fifo_radr), 32'd0);
    check("rst_rpt",   32'(fifo_rpt_update_hdclk), 32'd0);
    check("rst_pixde", 32'(pix_de), 32'd0);
    check("rst_rgb",   {8'h0, pix_r, pix_g, pix_b}, 32'd0);
    check("rst_ur",    32'(underrun), 32'd0);
    check("rst_state", 32'(dut.state), 32'(ST_IDLE));
    rst_hdclk = 1'b0;
    tick();

    // Start: run, FIFO non-empty, arm, then frame start.
    run_hdmi = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("armed", 32'(dut.state), 32'(ST_ARMED));
    vid_fs = 1'b1;
    tick();
    vid_fs = 1'b0;
    check("active", 32'(dut.state), 32'(ST_ACTIVE));

    run_line(128, 134, -1, -1, -1, pulses);
    check("pulses_4blk", 32'(pulses), 32'd4);
    check("ur_clean", 32'(underrun), 32'd0);

    // Second pass: colour word at address 0, empty across block 1 word 8.
    mem[0] = 32'hF800_07E0;
    run_line(128, 134, 40, 50, 48, pulses);
    check("pulses_pass2", 32'(pulses), 32'd4);
    check("pix0_green", {8'h0, cap0}, 32'h0000_FF00);
    check("pix1_red",   {8'h0, cap1}, 32'h00FF_0000);
    check("ur_sticky", 32'(underrun), 32'd1);
`ifdef HDMI_UNDERRUN_CNT_EN
    check("ur_cnt", 32'(underrun_cnt), 32'd1);
`endif

    // Drop run mid-line.
    for (int j = 0; j < 14; j++) begin
      if (j == 13) begin
        check("drop_state", 32'(dut.state), 32'(ST_IDLE));
        check("drop_pixde", 32'(pix_de), 32'd0);
        check("drop_radr",  32'(fifo_radr), 32'd0);
        check("drop_ur",    32'(underrun), 32'd1);
      end
      run_hdmi = (j < 10);
      vid_de   = (j < 13);
      tick();
    end
    for (int j = 0; j < 7; j++) begin
      if (j == 2) check("rerun_ur_hold", 32'(underrun), 32'd1);
      if (j == 3) begin
        check("rerun_ur_clr", 32'(underrun), 32'd0);
        check("rerun_state",  32'(dut.state), 32'(ST_WAIT_FILL));
`ifdef HDMI_UNDERRUN_CNT_EN
        check("rerun_cnt_clr", 32'(underrun_cnt), 32'd0);
`endif
      end
      run_hdmi = 1'b1;
      tick();
    end
    check("rearmed", 32'(dut.state), 32'(ST_ARMED));
    vid_fs = 1'b1;
    tick();
    vid_fs = 1'b0;

    // Reach blk=2 word=5, then reset with vid_de still high.
    run_line(74, 74, -1, -1, -1, pulses);
    check("pre_rst_radr",  32'(fifo_radr), 32'd37);
    check("pre_rst_pixde", 32'(pix_de), 32'd1);
    rst_hdclk = 1'b1;
    #1;
    check("mid_rst_radr",  32'(fifo_radr), 32'd0);
    check("mid_rst_pixde", 32'(pix_de), 32'd0);
    check("mid_rst_rpt",   32'(fifo_rpt_update_hdclk), 32'd0);
    check("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
    vid_de = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
